// File: rtl/alu_pkg.sv
// Shared ALU definitions: alucontrol codes and the alu_seq FSM state type.
// Used by both the ALU decoder and the sequential execution unit.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_ZFR = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_seq_state_t;

  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_ZFR);
  endfunction

endpackage

// File: rtl/alu_seq_shift.sv
// Shift/mask engine for sll and zfr: iterative work register plus down-counter,
// or a combinational barrel unit when ALU_SEQ_FAST_SHIFT_EN is defined.
module alu_seq_shift
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic             last_o,
  output logic [WIDTH-1:0] res_o
);

`ifdef ALU_SEQ_FAST_SHIFT_EN

  logic unused;
  assign unused = &{1'b0, clk, reset, load_i, step_i};

  assign res_o  = (op_i == ALU_SLL) ? (b_i << shamt_i)
                                    : (a_i & ({WIDTH{1'b1}} << shamt_i));
  assign last_o = 1'b1;

`else

  // sll shifts the work value; zfr keeps it and shifts a clearing mask instead.
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [SHW-1:0]   cnt_q;
  logic             sll_q;

  // NOTE: every signal written in always_comb gets a value on every path so no latch is inferred.
  always_comb begin
    work_d = sll_q ? (work_q << 1) : work_q;
    mask_d = sll_q ? mask_q : (mask_q << 1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      work_q <= '0;
      mask_q <= '1;
      cnt_q  <= '0;
      sll_q  <= 1'b0;
    end else if (load_i) begin
      sll_q  <= (op_i == ALU_SLL);
      work_q <= (op_i == ALU_SLL) ? b_i : a_i;
      mask_q <= '1;
      cnt_q  <= shamt_i;
    end else if (step_i) begin
      work_q <= work_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_q - SHW'(1);
    end
  end

  // res_o is the value after the current step, so it is final when last_o is high.
  assign res_o  = work_d & mask_d;
  assign last_o = (cnt_q == SHW'(1));

`endif

endmodule

// File: rtl/alu_seq.sv
// Multicycle execution unit with start/done handshake and registered outputs.
// Define ALU_SEQ_FAST_SHIFT_EN for single-cycle sll/zfr.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  alu_seq_state_t   state_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             err_q;

  logic [WIDTH-1:0] imm_res;
  logic             imm_err;
  logic             imm_iter;
  logic             accept;
  logic             sh_last;
  logic [WIDTH-1:0] sh_res;

  assign accept = start && (state_q != SHIFT);

  always_comb begin
    imm_res = '0;
    imm_err = 1'b0;
    case (alucontrol)
      ALU_ADD: imm_res = a + b;
      ALU_SUB: imm_res = a - b;
      ALU_AND: imm_res = a & b;
      ALU_OR:  imm_res = a | b;
      ALU_SLT: imm_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_SEQ_FAST_SHIFT_EN
      ALU_SLL, ALU_ZFR: imm_res = sh_res;
`else
      // Only reached here with shamt==0, where both ops pass their operand through.
      ALU_SLL: imm_res = b;
      ALU_ZFR: imm_res = a;
`endif
      default: imm_err = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_FAST_SHIFT_EN
  assign imm_iter = 1'b0;
`else
  assign imm_iter = is_shift_op(alucontrol) && (shamt != '0);
`endif

  alu_seq_shift #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load_i  (accept && imm_iter),
    .step_i  (state_q == SHIFT),
    .op_i    (alucontrol),
    .a_i     (a),
    .b_i     (b),
    .shamt_i (shamt),
    .last_o  (sh_last),
    .res_o   (sh_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SHIFT: begin
          if (sh_last) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= sh_res;
            zero_q   <= (sh_res == '0);
            err_q    <= 1'b0;
          end
        end
        default: begin
          // IDLE and DONE accept start identically, giving one simple op per cycle.
          if (accept) begin
            if (imm_iter) begin
              state_q <= SHIFT;
            end else begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= imm_res;
              zero_q   <= (imm_res == '0);
              err_q    <= imm_err;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; expected values are hand-computed.
// Latency expectations follow ALU_SEQ_FAST_SHIFT_EN when it is defined.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;
`ifdef ALU_SEQ_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       alucontrol;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .shamt      (shamt),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .zero       (zero),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one cycle (cycle 0), then scramble the operand inputs.
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [SHW-1:0] sh);
    alucontrol = op;
    a          = x;
    b          = y;
    shamt      = sh;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    alucontrol = 4'($urandom);
    a          = $urandom;
    b          = $urandom;
    shamt      = SHW'($urandom);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " busy"},   32'(busy),  32'd0);
    check({tag, " done"},   32'(done),  32'd0);
    check({tag, " result"}, result,     32'd0);
    check({tag, " zero"},   32'(zero),  32'd1);
    check({tag, " err"},    32'(err),   32'd0);
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_res, input logic exp_err);
    issue(op, x, y, 5'd0);
    check({tag, " done"},   32'(done), 32'd1);
    check({tag, " result"}, result,    exp_res);
    check({tag, " zero"},   32'(zero), 32'(exp_res == 32'd0));
    check({tag, " err"},    32'(err),  32'(exp_err));
    tick();
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " held"},       result,    exp_res);
  endtask

  task automatic run_shift(input string tag, input logic [3:0] op, input logic [31:0] x,
                           input logic [31:0] y, input logic [SHW-1:0] sh,
                           input logic [31:0] exp_res);
    int lat;
    lat = (FAST || sh == '0) ? 1 : int'(sh) + 1;
    issue(op, x, y, sh);
    for (int c = 1; c <= lat; c++) begin
      check($sformatf("%s c%0d busy,done", tag, c), {30'd0, busy, done},
            {30'd0, (c < lat), (c == lat)});
      if (c < lat) tick();
    end
    check({tag, " result"}, result,    exp_res);
    check({tag, " zero"},   32'(zero), 32'(exp_res == 32'd0));
    check({tag, " err"},    32'(err),  32'd0);
    tick();
    check({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bb_a   [4];
    logic [31:0] bb_b   [4];
    logic [31:0] bb_exp [4];
    int          sll_done_c;

    // Reset held with start asserted: reset must win.
    reset      = 1'b1;
    start      = 1'b1;
    alucontrol = ALU_ADD;
    a          = 32'd1;
    b          = 32'd1;
    shamt      = '0;
    tick();
    tick();
    reset = 1'b0;
    start = 1'b0;
    check_reset_state("reset");
    tick();
    check("post-reset done", 32'(done), 32'd0);

    do_op("add 7+5",      ALU_ADD, 32'd7,          32'd5,          32'd12,     1'b0);
    do_op("sub 5-5",      ALU_SUB, 32'd5,          32'd5,          32'd0,      1'b0);
    do_op("slt -1<1",     ALU_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1,      1'b0);
    do_op("slt 1<-1",     ALU_SLT, 32'd1,          32'hFFFF_FFFF,  32'd0,      1'b0);
    do_op("and",          ALU_AND, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000, 1'b0);
    do_op("or",           ALU_OR,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0, 1'b0);

    run_shift("sll 3<<4",   ALU_SLL, 32'h1234_5678, 32'd3,         5'd4, 32'h0000_0030);
    run_shift("zfr 8",      ALU_ZFR, 32'hFFFF_FFFF, 32'h0,         5'd8, 32'hFFFF_FF00);
    run_shift("sll sh0",    ALU_SLL, 32'h0,         32'h0000_1234, 5'd0, 32'h0000_1234);
    run_shift("zfr sh0",    ALU_ZFR, 32'h0000_ABCD, 32'h0,         5'd0, 32'h0000_ABCD);

    do_op("illegal 1111", 4'b1111, 32'd9, 32'd9, 32'd0, 1'b1);
    do_op("add clr err",  ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0);

    // sll shamt=10 with start re-pulsed in cycles 2-5 carrying add operands.
    sll_done_c = FAST ? 1 : 11;
    issue(ALU_SLL, 32'h0, 32'd1, 5'd10);
    for (int c = 1; c <= 12; c++) begin
      start      = (c >= 2 && c <= 5);
      alucontrol = ALU_ADD;
      a          = 32'(c);
      b          = 32'(c * 3);
      check($sformatf("repulse c%0d done", c), 32'(done),
            32'(FAST ? (c == 1 || (c >= 3 && c <= 6)) : (c == 11)));
      if (!FAST) check($sformatf("repulse c%0d busy", c), 32'(busy), 32'(c <= 10));
      if (c == sll_done_c) begin
        check("repulse result", result, 32'h0000_0400);
        check("repulse err",    32'(err), 32'd0);
      end
      tick();
    end
    start = 1'b0;

    // Reset asserted in cycle 3 of a shift: no done afterwards, outputs at reset values.
    issue(ALU_SLL, 32'h0, 32'd1, 5'd10);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("mid-shift reset");
    for (int c = 0; c < 12; c++) begin
      tick();
      check($sformatf("after reset c%0d done", c), 32'(done), 32'd0);
    end

    // Back-to-back adds: start held 4 cycles, one done per cycle.
    bb_a[0] = 32'd1;          bb_b[0] = 32'd1;  bb_exp[0] = 32'd2;
    bb_a[1] = 32'd2;          bb_b[1] = 32'd3;  bb_exp[1] = 32'd5;
    bb_a[2] = 32'd10;         bb_b[2] = 32'd20; bb_exp[2] = 32'd30;
    bb_a[3] = 32'hFFFF_FFFF;  bb_b[3] = 32'd1;  bb_exp[3] = 32'd0;
    for (int c = 0; c <= 5; c++) begin
      start = (c < 4);
      if (c < 4) begin
        alucontrol = ALU_ADD;
        a          = bb_a[c];
        b          = bb_b[c];
      end
      if (c >= 1) begin
        check($sformatf("b2b c%0d done", c), 32'(done), 32'(c <= 4));
        if (c <= 4) begin
          check($sformatf("b2b c%0d result", c), result, bb_exp[c-1]);
          check($sformatf("b2b c%0d zero", c), 32'(zero), 32'(bb_exp[c-1] == 32'd0));
        end
      end
      tick();
    end
    start = 1'b0;

    run_shift("sll 1<<31", ALU_SLL, 32'h0, 32'd1, 5'd31, 32'h8000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
